// File: rtl/mdc_reorder.sv
// Output reorder buffer for the 32-point radix-2 MDC FFT: bit-reversed pair beats in,
// natural-order bin pairs out over valid/ready, ping-pong banks with frame-drop detection.
module mdc_reorder #(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             di_en,
   input  logic [WIDTH-1:0] di0_re,
   input  logic [WIDTH-1:0] di0_im,
   input  logic [WIDTH-1:0] di1_re,
   input  logic [WIDTH-1:0] di1_im,
   output logic             do_valid,
   input  logic             do_ready,
   output logic [WIDTH-1:0] do0_re,
   output logic [WIDTH-1:0] do0_im,
   output logic [WIDTH-1:0] do1_re,
   output logic [WIDTH-1:0] do1_im,
   output logic [3:0]       do_index,
   output logic             do_last,
   output logic             overflow
);

   localparam int PW = 4 * WIDTH;

   typedef enum logic {IDLE, SEND} state_t;

   state_t          state, state_nx;
   logic [PW-1:0]   mem [2][16];
   logic [3:0]      wr_cnt;
   logic            wr_bank, rd_bank, rd_bank_nx;
   logic            drop_mode;
   logic [1:0]      full, full_nx;

   logic            hs, free_now, eff_full, drop_beat, wr_en, wr_last;
   logic            load, load_bank, valid_nx;
   logic [3:0]      load_word;
   logic [PW-1:0]   load_pair;

   function automatic logic [3:0] rev4(input logic [3:0] k);
      return {k[0], k[1], k[2], k[3]};
   endfunction

   // Write side: a bank freed by this cycle's final handshake counts as empty for beat 0.
   always_comb begin
      hs        = do_valid && do_ready;
      free_now  = hs && do_last;
      eff_full  = full[wr_bank] && !(free_now && (rd_bank == wr_bank));
      drop_beat = (wr_cnt == 4'd0) ? eff_full : drop_mode;
      wr_en     = di_en && !drop_beat;
      wr_last   = wr_en && (wr_cnt == 4'd15);
   end

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nx   = state;
      valid_nx   = do_valid;
      rd_bank_nx = rd_bank;
      load       = 1'b0;
      load_bank  = rd_bank;
      load_word  = 4'd0;
      full_nx    = full;
      case (state)
         IDLE: begin
            if (full[rd_bank]) begin
               load     = 1'b1;
               valid_nx = 1'b1;
               state_nx = SEND;
            end
         end
         SEND: begin
            if (hs) begin
               if (!do_last) begin
                  load      = 1'b1;
                  load_word = do_index + 4'd1;
               end else begin
                  full_nx[rd_bank] = 1'b0;
                  rd_bank_nx       = !rd_bank;
                  load_bank        = !rd_bank;
                  if (full[!rd_bank]) begin
                     load = 1'b1;
                  end else begin
                     valid_nx = 1'b0;
                     state_nx = IDLE;
                  end
               end
            end
         end
         default: state_nx = IDLE;
      endcase
      if (wr_last) full_nx[wr_bank] = 1'b1;
      load_pair = mem[load_bank][load_word];
   end

   // NOTE: state and registers use non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         do_valid <= 1'b0;
         rd_bank  <= 1'b0;
         full     <= 2'b00;
         do0_re   <= '0;
         do0_im   <= '0;
         do1_re   <= '0;
         do1_im   <= '0;
         do_index <= 4'd0;
         do_last  <= 1'b0;
      end else begin
         state    <= state_nx;
         do_valid <= valid_nx;
         rd_bank  <= rd_bank_nx;
         full     <= full_nx;
         if (load) begin
            {do0_re, do0_im, do1_re, do1_im} <= load_pair;
            do_index <= load_word;
            do_last  <= (load_word == 4'd15);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt    <= 4'd0;
         wr_bank   <= 1'b0;
         drop_mode <= 1'b0;
         overflow  <= 1'b0;
      end else if (di_en) begin
         wr_cnt <= wr_cnt + 4'd1;
         if (wr_last) wr_bank <= !wr_bank;
         if (wr_cnt == 4'd0 && eff_full) begin
            drop_mode <= 1'b1;
            overflow  <= 1'b1;
         end else if (wr_cnt == 4'd15) begin
            drop_mode <= 1'b0;
         end
      end
   end

   // NOTE: the storage is reset because a mid-frame reset must discard everything held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++)
            for (int w = 0; w < 16; w++)
               mem[b][w] <= '0;
      end else if (wr_en) begin
         mem[wr_bank][rev4(wr_cnt)] <= {di0_re, di0_im, di1_re, di1_im};
      end
   end

endmodule

// File: tb/tb_mdc_reorder.sv
// Scoreboard bench for mdc_reorder: frames are driven in bit-reversed order and the
// natural-order pairs expected at the output are queued and compared as they are accepted.
module tb_mdc_reorder;

   localparam int W = 9;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         di_en = 1'b0;
   logic [W-1:0] di0_re = '0, di0_im = '0, di1_re = '0, di1_im = '0;
   logic         do_valid, do_last, overflow;
   logic         do_ready = 1'b1;
   logic [W-1:0] do0_re, do0_im, do1_re, do1_im;
   logic [3:0]   do_index;

   mdc_reorder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .di_en(di_en),
      .di0_re(di0_re), .di0_im(di0_im), .di1_re(di1_re), .di1_im(di1_im),
      .do_valid(do_valid), .do_ready(do_ready),
      .do0_re(do0_re), .do0_im(do0_im), .do1_re(do1_re), .do1_im(do1_im),
      .do_index(do_index), .do_last(do_last), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] re0, im0, re1, im1;
      logic [3:0]   idx;
      logic         last;
   } pair_t;

   pair_t sb[$];
   int    n_chk = 0, n_fail = 0, n_pop = 0, bubbles = 0;
   logic  prev_valid = 1'b0, hold_pend = 1'b0;
   pair_t held, cur, exp_p;
   bit    rdy_pat = 1'b0;
   logic  rdy_level = 1'b1;
   int    rdy_cnt = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] rev4(input logic [3:0] k);
      return {k[0], k[1], k[2], k[3]};
   endfunction

   // Ready driver: fixed level, or the repeating 1,0,0,1 stall pattern.
   always @(posedge clk) begin
      #1;
      if (rdy_pat) begin
         do_ready = (rdy_cnt % 4 == 0) || (rdy_cnt % 4 == 3);
         rdy_cnt++;
      end else begin
         do_ready = rdy_level;
      end
   end

   // Monitor: sample mid-cycle, compare accepted pairs, check stall stability and gaps.
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pend  = 1'b0;
         prev_valid = 1'b0;
      end else begin
         cur = {do0_re, do0_im, do1_re, do1_im, do_index, do_last};
         if (hold_pend) check("stall_stable", cur, held);
         if (prev_valid && !do_valid && sb.size() != 0) bubbles++;
         hold_pend = do_valid && !do_ready;
         held      = cur;
         if (do_valid && do_ready) begin
            if (sb.size() == 0) begin
               check("spurious_pair", 64'(sb.size()), 64'd1);
            end else begin
               exp_p = sb.pop_front();
               check("pair", cur, exp_p);
            end
            n_pop++;
         end
         prev_valid = do_valid;
      end
   end

   task automatic apply_reset();
      rst_n = 1'b0;
      di_en = 1'b0;
      #1;
      check("rst_valid", do_valid, 1'b0);
      check("rst_data", {do0_re, do0_im, do1_re, do1_im}, '0);
      check("rst_idx_last_ovf", {do_index, do_last, overflow}, '0);
      sb.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Starts and ends at posedge+1; consecutive calls keep di_en continuous.
   task automatic send_frame(input int base, input int nbeats, input bit expect_out);
      logic [W-1:0] v;
      pair_t p;
      if (expect_out) begin
         for (int j = 0; j < 16; j++) begin
            v      = W'(base + 2 * j);
            p.re0  = v;
            p.im0  = -v;
            p.re1  = v + 1'b1;
            p.im1  = -(v + 1'b1);
            p.idx  = 4'(j);
            p.last = (j == 15);
            sb.push_back(p);
         end
      end
      for (int k = 0; k < nbeats; k++) begin
         v      = W'(base + 2 * int'(rev4(4'(k))));
         di_en  = 1'b1;
         di0_re = v;
         di0_im = -v;
         di1_re = v + 1'b1;
         di1_im = -(v + 1'b1);
         @(posedge clk);
         #1;
         di_en = 1'b0;
      end
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int c = 0;
      while (sb.size() != 0 && c < budget) begin
         @(posedge clk);
         c++;
      end
      check(tag, 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   int pops0, bub0;

   initial begin
      apply_reset();

      // Single frame with latency check.
      rdy_level = 1'b1;
      pops0 = n_pop;
      send_frame(0, 16, 1'b1);
      @(negedge clk);
      check("lat_after_e", do_valid, 1'b0);
      @(negedge clk);
      check("lat_after_e1", do_valid, 1'b1);
      wait_drain("single_drain", 100);
      check("single_pops", 64'(n_pop - pops0), 64'd16);

      // Back-to-back frames; frame 3 beat 0 lands on bank 0's final handshake.
      apply_reset();
      pops0 = n_pop;
      bub0  = bubbles;
      send_frame(0, 16, 1'b1);
      send_frame(40, 16, 1'b1);
      send_frame(80, 16, 1'b1);
      send_frame(120, 16, 1'b1);
      wait_drain("b2b_drain", 200);
      check("b2b_pops", 64'(n_pop - pops0), 64'd64);
      check("b2b_bubbles", 64'(bubbles - bub0), 64'd0);
      check("b2b_overflow", overflow, 1'b0);

      // Backpressure with the 1,0,0,1 ready pattern.
      apply_reset();
      rdy_pat = 1'b1;
      pops0 = n_pop;
      send_frame(10, 16, 1'b1);
      send_frame(60, 16, 1'b1);
      wait_drain("bp_drain", 400);
      check("bp_pops", 64'(n_pop - pops0), 64'd32);
      check("bp_overflow", overflow, 1'b0);
      rdy_pat = 1'b0;

      // Overflow: three frames with no drain, third is dropped.
      rdy_level = 1'b0;
      apply_reset();
      pops0 = n_pop;
      send_frame(0, 16, 1'b1);
      send_frame(100, 16, 1'b1);
      send_frame(200, 16, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("ovf_flag", overflow, 1'b1);
      check("ovf_held_valid", do_valid, 1'b1);
      check("ovf_held_pair0", {do0_re, do_index}, {9'd0, 4'd0});
      rdy_level = 1'b1;
      wait_drain("ovf_drain", 200);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("ovf_idle_valid", do_valid, 1'b0);
      check("ovf_pops", 64'(n_pop - pops0), 64'd32);
      check("ovf_sticky", overflow, 1'b1);

      // Reset mid-frame with do_valid held high.
      @(posedge clk);
      #1;
      rdy_level = 1'b0;
      apply_reset();
      send_frame(5, 16, 1'b1);
      send_frame(60, 8, 1'b0);
      @(negedge clk);
      check("mid_valid_before_rst", do_valid, 1'b1);
      #2;
      apply_reset();
      rdy_level = 1'b1;
      @(posedge clk);
      #1;
      pops0 = n_pop;
      send_frame(30, 16, 1'b1);
      wait_drain("post_rst_drain", 100);
      check("post_rst_pops", 64'(n_pop - pops0), 64'd16);
      check("post_rst_overflow", overflow, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
